// File: rtl/sensor_collector_pkg.sv
// sensor_collector_pkg: shared temperature constants, the collector FSM
// encoding and the reading range helper used by the optional range check.
package sensor_collector_pkg;

  localparam int TEMP_WIDTH = 8;
  localparam int S_NR       = 3;
  localparam logic [TEMP_WIDTH-1:0] T_MIN = TEMP_WIDTH'(20);
  localparam logic [TEMP_WIDTH-1:0] T_MAX = TEMP_WIDTH'(40);

  // Sensor index width and the index of the last sensor in a scan.
  localparam int SEL_W = $clog2(S_NR);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(S_NR - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when a reading lies inside the inclusive [T_MIN, T_MAX] window.
  function automatic logic in_range(input logic [TEMP_WIDTH-1:0] t);
    return (t >= T_MIN) && (t <= T_MAX);
  endfunction

endpackage

// File: rtl/sensor_poll_timer.sv
// sensor_poll_timer: counts cycles spent waiting for a sensor acknowledge and
// flags the last allowed waiting cycle. clr_i holds the count at zero, so the
// count restarts from zero on every entry into the waiting state.
module sensor_poll_timer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expired_o
);

  // Count value seen during the TIMEOUT_CYCLES-th waiting cycle.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_r;

  // Wait counter: cleared outside the waiting state, saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= 8'd0;
    end else if (clr_i) begin
      count_r <= 8'd0;
    end else if (count_r != LIMIT) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired_o = (count_r == LIMIT) && !clr_i;

endmodule

// File: rtl/sensor_collector.sv
// sensor_collector: polls S_NR temperature sensors one after another, stages
// each reading (or a zeroed, invalid slot on timeout) and publishes the whole
// frame atomically with a one-cycle frame_valid_o pulse.
// Optional feature macro: SENSOR_RANGE_CHECK_EN -- acknowledged readings
// outside [T_MIN, T_MAX] are stored but marked invalid.
module sensor_collector
  import sensor_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic [SEL_W-1:0]             sens_sel_o,
  output logic                         sens_req_o,
  input  logic                         sens_ack_i,
  input  logic [TEMP_WIDTH-1:0]        sens_data_i,
  output logic [S_NR*TEMP_WIDTH-1:0]   sensors_data_o,
  output logic [S_NR-1:0]              sensors_en_o,
  output logic                         frame_valid_o,
  output logic                         busy_o
);

  state_t                       state_r;
  state_t                       state_s;
  logic [SEL_W-1:0]             sel_r;
  logic [SEL_W-1:0]             sel_s;
  logic                         expired_s;
  logic                         ack_take_s;
  logic                         timeout_s;
  logic                         ack_en_s;
  logic                         publish_s;
  logic [S_NR*TEMP_WIDTH-1:0]   stage_data_r;
  logic [S_NR-1:0]              stage_en_r;

  sensor_poll_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_r != ST_REQ),
    .expired_o(expired_s)
  );

  // An ack on the last allowed cycle wins over the timeout.
  assign ack_take_s = (state_r == ST_REQ) && sens_ack_i;
  assign timeout_s  = (state_r == ST_REQ) && !sens_ack_i && expired_s;
  assign publish_s  = (state_r == ST_NEXT) && (state_s == ST_DONE);
  assign sens_sel_o = sel_r;

`ifdef SENSOR_RANGE_CHECK_EN
  assign ack_en_s = in_range(sens_data_i);
`else
  assign ack_en_s = 1'b1;
`endif

  // Next-state and next-select logic for the scan sequencer.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_REQ;
          sel_s   = {SEL_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sens_ack_i || expired_s) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_NEXT: begin
        if (sel_r < LAST_SEL) begin
          state_s = ST_REQ;
          sel_s   = sel_r + SEL_W'(1);
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        sel_s   = {SEL_W{1'b0}};
      end
    endcase
  end

  // State, select and the per-state control outputs, all registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      sel_r         <= {SEL_W{1'b0}};
      sens_req_o    <= 1'b0;
      frame_valid_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      sens_req_o    <= (state_s == ST_REQ);
      frame_valid_o <= (state_s == ST_DONE);
      busy_o        <= (state_s != ST_IDLE);
    end
  end

  // Staging slots: capture an acknowledged reading or clear the slot on timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_data_r <= {(S_NR*TEMP_WIDTH){1'b0}};
      stage_en_r   <= {S_NR{1'b0}};
    end else begin
      for (int i = 0; i < S_NR; i++) begin
        if (sel_r == SEL_W'(i)) begin
          if (ack_take_s) begin
            stage_data_r[i*TEMP_WIDTH +: TEMP_WIDTH] <= sens_data_i;
            stage_en_r[i]                            <= ack_en_s;
          end else if (timeout_s) begin
            stage_data_r[i*TEMP_WIDTH +: TEMP_WIDTH] <= {TEMP_WIDTH{1'b0}};
            stage_en_r[i]                            <= 1'b0;
          end else begin
            stage_data_r[i*TEMP_WIDTH +: TEMP_WIDTH] <= stage_data_r[i*TEMP_WIDTH +: TEMP_WIDTH];
            stage_en_r[i]                            <= stage_en_r[i];
          end
        end
      end
    end
  end

  // Published frame: copied from staging only on the edge that enters DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sensors_data_o <= {(S_NR*TEMP_WIDTH){1'b0}};
      sensors_en_o   <= {S_NR{1'b0}};
    end else if (publish_s) begin
      sensors_data_o <= stage_data_r;
      sensors_en_o   <= stage_en_r;
    end else begin
      sensors_data_o <= sensors_data_o;
      sensors_en_o   <= sensors_en_o;
    end
  end

endmodule

// File: tb/tb_sensor_collector.sv
// tb_sensor_collector: table-driven scans with hand-computed frames, plus
// hand-written sequences for reset during a scan and back-to-back starts.
// Expected enable bits follow SENSOR_RANGE_CHECK_EN when it is defined.
module tb_sensor_collector;

  localparam int TW = 8;
  localparam int SN = 3;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [1:0]       sens_sel_o;
  logic             sens_req_o;
  logic             sens_ack_i;
  logic [TW-1:0]    sens_data_i;
  logic [SN*TW-1:0] sensors_data_o;
  logic [SN-1:0]    sensors_en_o;
  logic             frame_valid_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .sens_sel_o    (sens_sel_o),
    .sens_req_o    (sens_req_o),
    .sens_ack_i    (sens_ack_i),
    .sens_data_i   (sens_data_i),
    .sensors_data_o(sensors_data_o),
    .sensors_en_o  (sensors_en_o),
    .frame_valid_o (frame_valid_o),
    .busy_o        (busy_o)
  );

  // One scan: readings, ack delay per sensor (REQ cycle index, >= TO never acks),
  // and the frame expected after publication.
  typedef struct {
    logic [7:0]  d0, d1, d2;
    int          w0, w1, w2;
    logic [23:0] exp_data;
    logic [2:0]  exp_en;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_scan(input vec_t v);
    logic [7:0] d[3];
    int w[3];
    int reqc;
    int idx;
    int early;
    int exp_req;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    idx = 0;
    early = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int s = 0; s < SN; s++) begin
      chk("req_enter", {31'd0, sens_req_o}, 32'd1);
      chk("sel", {30'd0, sens_sel_o}, s);
      chk("busy_scan", {31'd0, busy_o}, 32'd1);
      reqc = 0;
      while (sens_req_o === 1'b1 && reqc < 4 * TO) begin
        sens_ack_i  = (reqc == w[s]);
        sens_data_i = d[s];
        if (frame_valid_o !== 1'b0) early++;
        @(negedge clk);
        idx++;
        reqc++;
      end
      sens_ack_i  = 1'b0;
      sens_data_i = 8'h00;
      exp_req = (w[s] < TO) ? w[s] + 1 : TO;
      chk("req_cycles", reqc, exp_req);
      if (frame_valid_o !== 1'b0) early++;
      @(negedge clk);
      idx++;
    end
    chk("no_early_frame", early, 32'd0);
    if (w[0] == 0 && w[1] == 0 && w[2] == 0) begin
      chk("frame_latency", idx, 2 * SN);
    end
    chk("frame_valid", {31'd0, frame_valid_o}, 32'd1);
    chk("frame_data", {8'd0, sensors_data_o}, {8'd0, v.exp_data});
    chk("frame_en", {29'd0, sensors_en_o}, {29'd0, v.exp_en});
    @(negedge clk);
    chk("frame_valid_drop", {31'd0, frame_valid_o}, 32'd0);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("frame_hold", {8'd0, sensors_data_o}, {8'd0, v.exp_data});
  endtask

  initial begin
    int n;
    int pulses;
    int bad_fv;
    int bad_busy;
    logic exp_fv;
    logic exp_busy;

    vecs[0] = '{8'd25, 8'd30, 8'd35, 0, 0, 0, 24'h231E19, 3'b111};
    vecs[1] = '{8'd21, 8'd99, 8'd40, 0, 255, 2, 24'h280015, 3'b101};
    vecs[2] = '{8'd20, 8'd33, 8'd30, 3, 1, 7, 24'h1E2114, 3'b111};
`ifdef SENSOR_RANGE_CHECK_EN
    vecs[3] = '{8'd50, 8'd25, 8'd30, 0, 0, 0, 24'h1E1932, 3'b110};
    vecs[5] = '{8'd19, 8'd41, 8'hFF, 0, 0, 0, 24'hFF2913, 3'b000};
`else
    vecs[3] = '{8'd50, 8'd25, 8'd30, 0, 0, 0, 24'h1E1932, 3'b111};
    vecs[5] = '{8'd19, 8'd41, 8'hFF, 0, 0, 0, 24'hFF2913, 3'b111};
`endif
    vecs[4] = '{8'd11, 8'd22, 8'd33, 255, 255, 255, 24'h000000, 3'b000};

    rst_i       = 1'b1;
    start_i     = 1'b0;
    sens_ack_i  = 1'b0;
    sens_data_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    // Reset state.
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_req", {31'd0, sens_req_o}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid_o}, 32'd0);
    chk("rst_sel", {30'd0, sens_sel_o}, 32'd0);
    chk("rst_data", {8'd0, sensors_data_o}, 32'd0);
    chk("rst_en", {29'd0, sensors_en_o}, 32'd0);

    // Table-driven scans.
    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i]);
    end

    // Reset while sensor 1 is being polled: scan abandoned, outputs cleared.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
    sens_ack_i  = 1'b1;
    sens_data_i = 8'd33;
    n = 0;
    while (!(sens_req_o === 1'b1 && sens_sel_o === 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sel1", {31'd0, (n < 20)}, 32'd1);
    sens_ack_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_data", {8'd0, sensors_data_o}, 32'd0);
    chk("midrst_en", {29'd0, sensors_en_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_req", {31'd0, sens_req_o}, 32'd0);
    chk("midrst_sel", {30'd0, sens_sel_o}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (frame_valid_o !== 1'b0 || busy_o !== 1'b0) pulses++;
      @(negedge clk);
    end
    chk("midrst_quiet", pulses, 32'd0);
    run_scan(vecs[0]);

    // start_i held for 20 edges with acks always high: frames every 8 cycles.
    sens_ack_i  = 1'b1;
    sens_data_i = 8'd25;
    start_i     = 1'b1;
    pulses   = 0;
    bad_fv   = 0;
    bad_busy = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (c == 19) start_i = 1'b0;
      exp_fv   = (c == 6) || (c == 14) || (c == 22);
      exp_busy = !((c == 7) || (c == 15) || (c >= 23));
      if (frame_valid_o === 1'b1) pulses++;
      if (frame_valid_o !== exp_fv) bad_fv++;
      if (busy_o !== exp_busy) bad_busy++;
    end
    sens_ack_i  = 1'b0;
    sens_data_i = 8'h00;
    chk("b2b_pulses", pulses, 32'd3);
    chk("b2b_fv_pattern", bad_fv, 32'd0);
    chk("b2b_busy_pattern", bad_busy, 32'd0);
    chk("b2b_data", {8'd0, sensors_data_o}, 32'h00191919);
    chk("b2b_en", {29'd0, sensors_en_o}, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_collector.md
SENSOR_COLLECTOR -- requirements
Module: sensor_collector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8, SHALL set the maximum cycles spent waiting for a sensor acknowledge (legal range 2..255).
REQ-002 Macros TEMP_WIDTH, S_NR, T_MIN and T_MAX SHALL come from the shared temperature package; S_NR >= 2.
REQ-003 clk_i  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-005 start_i  in  1  SHALL request one scan of all sensors; it is sampled only in IDLE.
REQ-006 sens_sel_o  out  clog2(S_NR)  SHALL give the index of the sensor being polled.
REQ-007 sens_req_o  out  1  SHALL be the registered read request to the selected sensor.
REQ-008 sens_ack_i  in  1  SHALL mark sens_data_i valid; it is ignored outside REQ.
REQ-009 sens_data_i  in  TEMP_WIDTH  SHALL carry the unsigned reading of the selected sensor.
REQ-010 sensors_data_o  out  S_NR*TEMP_WIDTH  SHALL be the packed frame, with sensor i at bits [i*TEMP_WIDTH +: TEMP_WIDTH]; it drives temperature_top sensors_data_i.
REQ-011 sensors_en_o  out  S_NR  SHALL be the per-sensor valid bits; it drives temperature_top sensors_en_i.
REQ-012 frame_valid_o  out  1  SHALL be a one-cycle pulse marking a newly published frame.
REQ-013 busy_o  out  1  SHALL be high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ, NEXT and DONE.
- IDLE->REQ on start_i; sel is set to 0.
- REQ->NEXT on ack or on timeout.
- NEXT->REQ with sel+1 when sel < S_NR-1, otherwise NEXT->DONE.
- DONE->IDLE unconditionally.
REQ-015 sens_req_o SHALL be high exactly while in REQ.
REQ-016 In REQ, an ack SHALL write sens_data_i into staging slot sel and set staging enable bit sel to 1.
REQ-017 A wait counter SHALL clear on REQ entry; if no ack has arrived by the TIMEOUT_CYCLES-th REQ cycle, staging slot sel SHALL be set to 0 and its enable bit to 0.
REQ-018 An ack on the final allowed REQ cycle SHALL take priority over the timeout.
REQ-019 Staging registers SHALL copy into sensors_data_o and sensors_en_o atomically on the edge that enters DONE; frame_valid_o SHALL be high during DONE only.
REQ-020 Outputs SHALL hold the last published frame between scans; a partial scan is never visible on them.
REQ-021 With ack in the first REQ cycle, start_i high at edge k SHALL give frame_valid_o high in cycle k+2*S_NR+1.
REQ-022 start_i SHALL be ignored while busy_o is high; start_i held high SHALL start back-to-back scans with one IDLE cycle between them.

Reset
REQ-023 rst_i SHALL set the following, with priority over all other activity:
- state IDLE, sel 0, wait counter 0;
- sens_req_o 0, frame_valid_o 0, busy_o 0;
- sensors_data_o, sensors_en_o and all staging registers to 0.
REQ-024 rst_i asserted during a scan SHALL abandon it with no frame_valid_o pulse and no partial publication.

Configuration
REQ-025 With SENSOR_RANGE_CHECK_EN defined, an acknowledged reading outside [T_MIN, T_MAX] SHALL be stored but its enable bit SHALL be set to 0.
REQ-026 Without SENSOR_RANGE_CHECK_EN, every acknowledged reading SHALL set its enable bit to 1 and no comparators are synthesized.

Structure
REQ-027 The shared temperature package SHALL hold TEMP_WIDTH, S_NR, T_MIN, T_MAX and the FSM state encoding.
REQ-028 The wait counter and timeout compare SHALL live in one sub-module, sensor_poll_timer, with inputs clk_i, rst_i and clr_i and output expired_o.

Verification
Bench configuration for all scenarios: S_NR=3, TEMP_WIDTH=8, T_MIN=20, T_MAX=40, TIMEOUT_CYCLES=8.
REQ-029 Start, immediate acks with data 25/30/35 -> sensors_data_o=0x231E19, sensors_en_o=3'b111, frame_valid_o high in cycle 7 after the start edge.
REQ-030 Sensor 1 never acks -> sens_req_o high 8 cycles for sel=1; result slot1=0, en=3'b101.
REQ-031 Sensor 2 acks on its 8th REQ cycle with data 30 -> the ack wins; en bit2=1, slot2=30.
REQ-032 Sensor 0 returns 50: with the macro en=3'b110; without the macro en=3'b111; slot0=50 in both builds.
REQ-033 rst_i pulsed while sel=1 -> all outputs 0, no frame_valid_o pulse; a new start_i completes a normal frame.
REQ-034 start_i held high for 20 cycles -> frames publish back-to-back with one IDLE cycle between; start_i during busy causes no restart.
